// File: rtl/cordic_arbiter.sv
// Round-robin front end sharing one CORDIC sine/cosine engine among NREQ clients.
// One transaction in flight at a time; a missing core_done becomes an error response after TIMEOUT.
module cordic_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 31
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req,
  input  logic [8*NREQ-1:0]         angle,
  output logic [NREQ-1:0]           grant,
  output logic                      busy,
  output logic                      core_start,
  output logic [7:0]                core_angle,
  input  logic                      core_done,
  input  logic [7:0]                core_sine,
  input  logic [7:0]                core_cosine,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [$clog2(NREQ)-1:0]   resp_id,
  output logic [7:0]                resp_sine,
  output logic [7:0]                resp_cosine,
  output logic                      resp_err,
  output logic                      timeout_err
);

  localparam int IDW = $clog2(NREQ);
  localparam int IW1 = IDW + 1;

  typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

  state_t          state, state_nxt;
  logic [IDW-1:0]  ptr, ptr_nxt;
  logic [IDW-1:0]  owner, owner_nxt;
  logic [IDW-1:0]  win;
  logic            found;
  logic [IDW:0]    idx;
  logic [7:0]      cnt, cnt_nxt;

  logic [NREQ-1:0] grant_nxt;
  logic            core_start_nxt;
  logic [7:0]      core_angle_nxt;
  logic            resp_valid_nxt;
  logic [IDW-1:0]  resp_id_nxt;
  logic [7:0]      resp_sine_nxt;
  logic [7:0]      resp_cosine_nxt;
  logic            resp_err_nxt;
  logic            timeout_err_nxt;

  assign busy = (state != IDLE);

  // First requesting index at or above ptr, wrapping past NREQ-1.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = {1'b0, ptr} + IW1'(i);
      if (idx >= IW1'(NREQ)) idx = idx - IW1'(NREQ);
      if (!found && req[idx[IDW-1:0]]) begin
        found = 1'b1;
        win   = idx[IDW-1:0];
      end
    end
  end

  always_comb begin
    state_nxt       = state;
    ptr_nxt         = ptr;
    owner_nxt       = owner;
    cnt_nxt         = cnt;
    grant_nxt       = '0;
    core_start_nxt  = 1'b0;
    core_angle_nxt  = core_angle;
    resp_valid_nxt  = resp_valid;
    resp_id_nxt     = resp_id;
    resp_sine_nxt   = resp_sine;
    resp_cosine_nxt = resp_cosine;
    resp_err_nxt    = resp_err;
    timeout_err_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt      = START;
          owner_nxt      = win;
          grant_nxt      = NREQ'(1) << win;
          core_start_nxt = 1'b1;
          core_angle_nxt = angle[{win, 3'b000} +: 8];
        end
      end
      START: begin
        state_nxt = WAIT;
        ptr_nxt   = (owner == IDW'(NREQ - 1)) ? '0 : owner + 1'b1;
        cnt_nxt   = '0;
      end
      WAIT: begin
        // A completion landing on the timeout cycle still counts as success.
        if (core_done) begin
          state_nxt       = RESP;
          resp_valid_nxt  = 1'b1;
          resp_id_nxt     = owner;
          resp_sine_nxt   = core_sine;
          resp_cosine_nxt = core_cosine;
          resp_err_nxt    = 1'b0;
        end else if (cnt == 8'(TIMEOUT)) begin
          state_nxt       = RESP;
          resp_valid_nxt  = 1'b1;
          resp_id_nxt     = owner;
          resp_sine_nxt   = '0;
          resp_cosine_nxt = '0;
          resp_err_nxt    = 1'b1;
          timeout_err_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_nxt      = IDLE;
          resp_valid_nxt = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= '0;
      owner       <= '0;
      cnt         <= '0;
      grant       <= '0;
      core_start  <= 1'b0;
      core_angle  <= '0;
      resp_valid  <= 1'b0;
      resp_id     <= '0;
      resp_sine   <= '0;
      resp_cosine <= '0;
      resp_err    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      ptr         <= ptr_nxt;
      owner       <= owner_nxt;
      cnt         <= cnt_nxt;
      grant       <= grant_nxt;
      core_start  <= core_start_nxt;
      core_angle  <= core_angle_nxt;
      resp_valid  <= resp_valid_nxt;
      resp_id     <= resp_id_nxt;
      resp_sine   <= resp_sine_nxt;
      resp_cosine <= resp_cosine_nxt;
      resp_err    <= resp_err_nxt;
      timeout_err <= timeout_err_nxt;
    end
  end

endmodule

// File: tb/tb_cordic_arbiter.sv
// Bench for cordic_arbiter: transaction-level reference model compared every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_cordic_arbiter;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 31;
  localparam int IDW     = $clog2(NREQ);

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [8*NREQ-1:0] angle;
  logic [NREQ-1:0]   grant;
  logic              busy;
  logic              core_start;
  logic [7:0]        core_angle;
  logic              core_done;
  logic [7:0]        core_sine;
  logic [7:0]        core_cosine;
  logic              resp_valid;
  logic              resp_ready;
  logic [IDW-1:0]    resp_id;
  logic [7:0]        resp_sine;
  logic [7:0]        resp_cosine;
  logic              resp_err;
  logic              timeout_err;

  always #5 clk = ~clk;

  cordic_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .angle(angle), .grant(grant), .busy(busy),
    .core_start(core_start), .core_angle(core_angle), .core_done(core_done),
    .core_sine(core_sine), .core_cosine(core_cosine), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_id(resp_id), .resp_sine(resp_sine),
    .resp_cosine(resp_cosine), .resp_err(resp_err), .timeout_err(timeout_err)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int eng_lat = 12;
  int eng_cnt = 0;
  int done_at = -1;
  bit cmp_en = 1'b0;
  int to_cnt = 0;
  int rv_cnt = 0;

  // Reference model state: owner of the open transaction, cycles since its grant.
  int m_owner = -1;
  int m_age = 0;
  bit m_resp = 1'b0;
  int m_ptr = 0;
  logic [NREQ-1:0] exp_grant = '0;
  logic exp_start = 1'b0, exp_busy = 1'b0, exp_valid = 1'b0, exp_err = 1'b0, exp_terr = 1'b0;
  logic [7:0] exp_angle = '0, exp_sin = '0, exp_cos = '0;
  int exp_id = 0;

  int g_id[$];
  int g_cyc[$];
  logic [7:0] g_ang[$];
  int r_id[$];
  int r_cyc[$];
  logic [7:0] r_sin[$];
  logic [7:0] r_cos[$];
  logic r_err[$];

  always @(posedge clk) begin
    int w;
    bit hit;
    cyc++;
    exp_grant = '0;
    exp_start = 1'b0;
    exp_terr  = 1'b0;
    if (rst) begin
      m_owner = -1; m_age = 0; m_resp = 1'b0; m_ptr = 0;
      exp_angle = '0; exp_valid = 1'b0; exp_err = 1'b0;
      exp_sin = '0; exp_cos = '0; exp_id = 0;
    end else if (m_resp) begin
      if (resp_ready) begin
        m_resp = 1'b0; m_owner = -1; exp_valid = 1'b0;
      end
    end else if (m_owner >= 0) begin
      if (m_age == 0) begin
        m_ptr = (m_owner + 1) % NREQ;
        m_age = 1;
      end else if (core_done || m_age == TIMEOUT + 1) begin
        m_resp    = 1'b1;
        exp_valid = 1'b1;
        exp_id    = m_owner;
        exp_err   = !core_done;
        exp_terr  = !core_done;
        exp_sin   = core_done ? core_sine : 8'h00;
        exp_cos   = core_done ? core_cosine : 8'h00;
        r_id.push_back(m_owner); r_cyc.push_back(cyc);
        r_sin.push_back(exp_sin); r_cos.push_back(exp_cos); r_err.push_back(exp_err);
      end else begin
        m_age++;
      end
    end else if (req != '0) begin
      hit = 1'b0;
      w = 0;
      for (int k = 0; k < NREQ; k++) begin
        if (!hit && req[(m_ptr + k) % NREQ]) begin
          hit = 1'b1;
          w = (m_ptr + k) % NREQ;
        end
      end
      m_owner   = w;
      m_age     = 0;
      exp_grant = NREQ'(1) << w;
      exp_start = 1'b1;
      exp_angle = angle[8*w +: 8];
      g_id.push_back(w); g_cyc.push_back(cyc); g_ang.push_back(exp_angle);
    end
    exp_busy = (m_owner >= 0);
  end

  // Engine stand-in: done eng_lat cycles after start (0 = never), or forced at done_at.
  always @(negedge clk) begin
    core_done = 1'b0;
    if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0) core_done = 1'b1;
    end
    if (cyc == done_at) core_done = 1'b1;
    if (core_start === 1'b1 && eng_lat > 0) eng_cnt = eng_lat;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_grants(input int n, input string name);
    int k = 0;
    while (g_id.size() < n && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk(name, 32'(g_id.size() >= n), 32'd1);
  endtask

  task automatic wait_resps(input int n, input string name);
    int k = 0;
    while (r_id.size() < n && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk(name, 32'(r_id.size() >= n), 32'd1);
  endtask

  initial begin
    int ng, nr, to0, rv0, s, h, k;
    int rr_exp[6] = '{0, 1, 2, 3, 0, 1};
    rst = 1'b1; req = '0; angle = '0; resp_ready = 1'b1;
    core_sine = 8'h00; core_cosine = 8'h00;

    fork
      forever begin
        @(negedge clk);
        if (cmp_en) begin
          chk("grant", 32'(grant), 32'(exp_grant));
          chk("core_start", 32'(core_start), 32'(exp_start));
          chk("busy", 32'(busy), 32'(exp_busy));
          chk("core_angle", 32'(core_angle), 32'(exp_angle));
          chk("resp_valid", 32'(resp_valid), 32'(exp_valid));
          chk("resp_id", 32'(resp_id), 32'(exp_id));
          chk("resp_sine", 32'(resp_sine), 32'(exp_sin));
          chk("resp_cosine", 32'(resp_cosine), 32'(exp_cos));
          chk("resp_err", 32'(resp_err), 32'(exp_err));
          chk("timeout_err", 32'(timeout_err), 32'(exp_terr));
          if (timeout_err === 1'b1) to_cnt++;
          if (resp_valid === 1'b1) rv_cnt++;
        end
      end
    join_none

    repeat (3) @(negedge clk);
    rst = 1'b0;
    cmp_en = 1'b1;
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_core_start", 32'(core_start), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
    chk("rst_core_angle", 32'(core_angle), 32'd0);

    // Spurious core_done while idle.
    done_at = cyc + 2;
    repeat (5) @(negedge clk);
    chk("spur_no_resp", 32'(r_id.size()), 32'd0);
    chk("spur_busy", 32'(busy), 32'd0);

    // Round robin with all requesters active.
    angle = 32'h40302010; core_sine = 8'h11; core_cosine = 8'h22;
    req = 4'b1111;
    wait_grants(6, "rr_grants");
    req = '0;
    wait_resps(6, "rr_resps");
    for (int i = 0; i < 6; i++) begin
      chk("rr_grant_id", 32'(g_id[i]), 32'(rr_exp[i]));
      chk("rr_resp_id", 32'(r_id[i]), 32'(rr_exp[i]));
      if (i > 0) chk("rr_spacing", 32'(g_cyc[i] - g_cyc[i-1]), 32'd15);
    end
    chk("rr_angle0", 32'(g_ang[0]), 32'h10);
    chk("rr_angle3", 32'(g_ang[3]), 32'h40);

    // Single request, 12-cycle engine.
    angle = 32'h00000032; core_sine = 8'h5A; core_cosine = 8'h5B;
    ng = g_id.size(); nr = r_id.size();
    req = 4'b0001;
    wait_grants(ng + 1, "single_grant");
    req = '0;
    chk("single_core_angle", 32'(core_angle), 32'h32);
    wait_resps(nr + 1, "single_resp");
    chk("single_gid", 32'(g_id[ng]), 32'd0);
    chk("single_rid", 32'(r_id[nr]), 32'd0);
    chk("single_sin", 32'(r_sin[nr]), 32'h5A);
    chk("single_cos", 32'(r_cos[nr]), 32'h5B);
    chk("single_err", 32'(r_err[nr]), 32'd0);
    chk("single_latency", 32'(r_cyc[nr] - g_cyc[ng]), 32'd13);

    // Backpressure with another request pending.
    @(negedge clk);
    resp_ready = 1'b0;
    ng = g_id.size();
    req = 4'b0110;
    wait_grants(ng + 1, "bp_grant1");
    req = 4'b0100;
    chk("bp_gid1", 32'(g_id[ng]), 32'd1);
    k = 0;
    while (resp_valid !== 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("bp_valid_seen", 32'(resp_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_id", 32'(resp_id), 32'd1);
      chk("bp_hold_sin", 32'(resp_sine), 32'h5A);
      chk("bp_hold_cos", 32'(resp_cosine), 32'h5B);
      chk("bp_no_grant", 32'(grant), 32'd0);
      chk("bp_no_start", 32'(core_start), 32'd0);
      @(negedge clk);
    end
    h = cyc;
    resp_ready = 1'b1;
    wait_grants(ng + 2, "bp_grant2");
    req = '0;
    chk("bp_gid2", 32'(g_id[ng+1]), 32'd2);
    chk("bp_grant2_cycle", 32'(g_cyc[ng+1]), 32'(h + 2));
    wait_resps(r_id.size() + 1, "bp_resp2");

    // Timeout: engine never completes.
    @(negedge clk);
    eng_lat = 0;
    ng = g_id.size(); nr = r_id.size(); to0 = to_cnt;
    req = 4'b1000;
    wait_grants(ng + 1, "to_grant");
    req = '0;
    wait_resps(nr + 1, "to_resp");
    @(negedge clk);
    chk("to_rid", 32'(r_id[nr]), 32'd3);
    chk("to_err", 32'(r_err[nr]), 32'd1);
    chk("to_sin", 32'(r_sin[nr]), 32'd0);
    chk("to_cos", 32'(r_cos[nr]), 32'd0);
    chk("to_latency", 32'(r_cyc[nr] - g_cyc[ng]), 32'd33);
    chk("to_pulses", 32'(to_cnt - to0), 32'd1);

    // Next request after a timeout proceeds normally.
    eng_lat = 12;
    ng = g_id.size(); nr = r_id.size();
    req = 4'b0001;
    wait_grants(ng + 1, "post_to_grant");
    req = '0;
    wait_resps(nr + 1, "post_to_resp");
    chk("post_to_rid", 32'(r_id[nr]), 32'd0);
    chk("post_to_err", 32'(r_err[nr]), 32'd0);

    // core_done on the very cycle the counter reaches TIMEOUT.
    @(negedge clk);
    eng_lat = TIMEOUT + 1;
    ng = g_id.size(); nr = r_id.size(); to0 = to_cnt;
    req = 4'b0010;
    wait_grants(ng + 1, "edge_grant");
    req = '0;
    wait_resps(nr + 1, "edge_resp");
    @(negedge clk);
    chk("edge_rid", 32'(r_id[nr]), 32'd1);
    chk("edge_err", 32'(r_err[nr]), 32'd0);
    chk("edge_sin", 32'(r_sin[nr]), 32'h5A);
    chk("edge_latency", 32'(r_cyc[nr] - g_cyc[ng]), 32'd33);
    chk("edge_no_pulse", 32'(to_cnt - to0), 32'd0);

    // Reset during WAIT cycle 5, then a late core_done.
    @(negedge clk);
    eng_lat = 0;
    ng = g_id.size();
    req = 4'b0100;
    wait_grants(ng + 1, "rm_grant");
    req = '0;
    s = g_cyc[ng];
    k = 0;
    while (cyc < s + 5 && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("rm_wait5", 32'(cyc), 32'(s + 5));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rm_busy", 32'(busy), 32'd0);
    chk("rm_grant", 32'(grant), 32'd0);
    chk("rm_angle", 32'(core_angle), 32'd0);
    chk("rm_valid", 32'(resp_valid), 32'd0);
    chk("rm_id", 32'(resp_id), 32'd0);
    chk("rm_sin", 32'(resp_sine), 32'd0);
    done_at = cyc + 3;
    rv0 = rv_cnt; nr = r_id.size();
    repeat (10) @(negedge clk);
    chk("rm_no_resp_dut", 32'(rv_cnt - rv0), 32'd0);
    chk("rm_no_resp_model", 32'(r_id.size()), 32'(nr));
    chk("rm_idle", 32'(busy), 32'd0);
    eng_lat = 12;
    ng = g_id.size();
    req = 4'b1100;
    wait_grants(ng + 1, "rm_next_grant");
    req = '0;
    chk("rm_next_gid", 32'(g_id[ng]), 32'd2);
    chk("rm_next_dut_grant", 32'(grant), 32'b0100);
    wait_resps(nr + 1, "rm_next_resp");
    chk("rm_next_rid", 32'(r_id[nr]), 32'd2);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
